msoc_mem_arbiter: RTL and testbench



---
 rtl/msoc_mem_pkg.sv | 24 ++
 rtl/msoc_mem_arbiter_if.sv | 49 ++++
 rtl/msoc_mem_arbiter_rr_grant.sv | 35 +++
 rtl/msoc_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_msoc_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/msoc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : msoc_mem_pkg
// Brief   : Shared sizing constants and helpers for the MSoC RAM arbiter.
// Revision: 1.0
// ============================================================================
package msoc_mem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    // Index width for n items; never returns less than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int v = 2; v < n; v = v * 2) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msoc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : msoc_mem_arbiter_if
// Brief   : Master-side Avalon-MM bundle plus RAM pins for the arbiter.
// Revision: 1.0
// ============================================================================
interface msoc_mem_arbiter_if
    import msoc_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = msoc_mem_pkg::ADDR_W,
    parameter int DATA_W      = msoc_mem_pkg::DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS*BE_W-1:0]   m_byteenable;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [DATA_W-1:0]             m_readdata;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;

    logic [ADDR_W-1:0]             mem_address;
    logic [BE_W-1:0]               mem_byteenable;
    logic                          mem_chipselect;
    logic                          mem_write;
    logic [DATA_W-1:0]             mem_writedata;
    logic                          mem_clken;
    logic [DATA_W-1:0]             mem_readdata;

    // Arbiter view: slave to the masters, driver of the RAM pins.
    modport slave (
        input  m_address, m_byteenable, m_read, m_write, m_writedata, mem_readdata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken
    );

    modport master (
        output m_address, m_byteenable, m_read, m_write, m_writedata, mem_readdata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken
    );

endinterface
`default_nettype wire

// File: rtl/msoc_mem_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant
// Brief   : Combinational round-robin picker: first requester at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_grant
    import msoc_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int PTR_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % NUM_MASTERS);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/msoc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : msoc_mem_arbiter
// Brief   : Round-robin sharing of one single-port RAM among Avalon-MM masters.
// Revision: 1.0
// ============================================================================
module msoc_mem_arbiter
    import msoc_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = msoc_mem_pkg::ADDR_W,
    parameter int DATA_W      = msoc_mem_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    msoc_mem_arbiter_if.slave  bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OWN_W = clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_rr_grant;
    logic [NUM_MASTERS-1:0] w_grant;
    logic [NUM_MASTERS-1:0] w_rdv;
    logic                   w_any;
    logic                   w_wr;
    logic                   w_rd;
    logic [OWN_W-1:0]       w_gidx;
    logic [ADDR_W-1:0]      w_addr;
    logic [BE_W-1:0]        w_be;
    logic [DATA_W-1:0]      w_wdata;

    logic [OWN_W-1:0]       r_rr_ptr;
    logic                   r_rd_pending;
    logic [OWN_W-1:0]       r_rd_owner;
    logic [ADDR_W-1:0]      r_last_addr;
    logic [BE_W-1:0]        r_last_be;
    logic [DATA_W-1:0]      r_last_wdata;

    assign w_req = bus.m_read | bus.m_write;

    rr_grant #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (OWN_W)
    ) u_rr_grant (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .grant (w_rr_grant)
    );

    // Suppressing the grant under reset makes waitrequest mirror req.
    assign w_grant           = reset ? '0 : w_rr_grant;
    assign w_any             = |w_grant;
    assign bus.m_waitrequest = w_req & ~w_grant;

    always_comb begin
        w_gidx  = '0;
        w_addr  = '0;
        w_be    = '0;
        w_wdata = '0;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_gidx  = OWN_W'(i);
                w_addr  = bus.m_address[i*ADDR_W +: ADDR_W];
                w_be    = bus.m_byteenable[i*BE_W +: BE_W];
                w_wdata = bus.m_writedata[i*DATA_W +: DATA_W];
                w_wr    = bus.m_write[i];
                w_rd    = bus.m_read[i] & ~bus.m_write[i];
            end
        end
    end

    assign bus.mem_address    = w_any ? w_addr  : r_last_addr;
    assign bus.mem_byteenable = w_any ? w_be    : r_last_be;
    assign bus.mem_writedata  = w_any ? w_wdata : r_last_wdata;
    assign bus.mem_chipselect = w_any;
    assign bus.mem_write      = w_wr;
    assign bus.mem_clken      = ~reset;
    assign bus.m_readdata     = bus.mem_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= '0;
            r_last_addr  <= '0;
            r_last_be    <= '0;
            r_last_wdata <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr     <= (w_gidx == OWN_W'(NUM_MASTERS - 1)) ? '0 : w_gidx + OWN_W'(1);
                r_last_addr  <= w_addr;
                r_last_be    <= w_be;
                r_last_wdata <= w_wdata;
            end
            r_rd_pending <= w_rd;
            if (w_rd) begin
                r_rd_owner <= w_gidx;
            end
        end
    end

    always_comb begin
        w_rdv = '0;
        if (r_rd_pending && !reset) begin
            w_rdv[r_rd_owner] = 1'b1;
        end
    end

    assign bus.m_readdatavalid = w_rdv;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rw_check
            a_rw_excl: assert property (@(posedge clk) disable iff (reset)
                !(bus.m_read[gi] && bus.m_write[gi]));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_msoc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_msoc_mem_arbiter
// Brief   : Directed self-checking bench for msoc_mem_arbiter with a RAM model.
// Revision: 1.0
// ============================================================================
module tb_msoc_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   c0, c1;

    always #5 clk = ~clk;

    msoc_mem_arbiter_if #(.NUM_MASTERS(2)) bus ();

    msoc_mem_arbiter #(.NUM_MASTERS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: byte-enabled writes, registered read output.
    logic [31:0] ram [8192];
    logic [31:0] ram_q = '0;
    assign bus.mem_readdata = ram_q;

    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_byteenable[b])
                        ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
                end
            end else begin
                ram_q <= ram[bus.mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic rd, input logic wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.m_read[m]                = rd;
        bus.m_write[m]               = wr;
        bus.m_address[m*13 +: 13]    = a;
        bus.m_byteenable[m*4 +: 4]   = be;
        bus.m_writedata[m*32 +: 32]  = wd;
    endtask

    task automatic idle();
        bus.m_read  = '0;
        bus.m_write = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_address    = '0;
        bus.m_byteenable = '0;
        bus.m_writedata  = '0;
        idle();
        drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        check("rst_waitreq", bus.m_waitrequest, 2'b01);
        check("rst_cs", bus.mem_chipselect, 1'b0);
        check("rst_clken", bus.mem_clken, 1'b0);
        check("rst_memwr", bus.mem_write, 1'b0);
        check("rst_rdv", bus.m_readdatavalid, 2'b00);

        // Single master write then read-back
        step();
        reset = 1'b0;
        idle();
        drive(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_waitreq", bus.m_waitrequest, 2'b00);
        check("wr_cs", bus.mem_chipselect, 1'b1);
        check("wr_memwr", bus.mem_write, 1'b1);
        check("wr_addr", bus.mem_address, 13'h0010);
        check("wr_clken", bus.mem_clken, 1'b1);
        step();
        drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        check("rd_waitreq", bus.m_waitrequest, 2'b00);
        check("rd_memwr", bus.mem_write, 1'b0);
        step();
        idle();
        @(negedge clk);
        check("rd_rdv", bus.m_readdatavalid, 2'b01);
        check("rd_data", bus.m_readdata, 32'hDEADBEEF);
        check("idle_cs", bus.mem_chipselect, 1'b0);
        check("idle_hold_addr", bus.mem_address, 13'h0010);

        // Byte-enable merge
        step();
        drive(0, 1'b0, 1'b1, 13'h0020, 4'hF, 32'h11223344);
        step();
        drive(0, 1'b0, 1'b1, 13'h0020, 4'h4, 32'hAABBCCDD);
        step();
        drive(0, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("be_rdv", bus.m_readdatavalid, 2'b01);
        check("be_data", bus.m_readdata, 32'h11BB3344);

        // Contention after reset: grants alternate starting at master 0
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) idle();
            @(negedge clk);
            if (k < 8)
                check($sformatf("ct_waitreq%0d", k), bus.m_waitrequest,
                      (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k >= 1) begin
                check($sformatf("ct_rdv%0d", k), bus.m_readdatavalid,
                      ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("ct_data%0d", k), bus.m_readdata,
                      ((k - 1) % 2 == 0) ? 32'hDEADBEEF : 32'h11BB3344);
            end
            if (bus.m_readdatavalid[0]) c0++;
            if (bus.m_readdatavalid[1]) c1++;
            step();
        end
        check("ct_count0", c0, 4);
        check("ct_count1", c1, 4);

        // Fairness: master 1 streams, master 0 joins in cycle 3
        drive(1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fr_m1only%0d", k), bus.m_waitrequest, 2'b00);
            step();
        end
        drive(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        check("fr_c3_waitreq", bus.m_waitrequest, 2'b10);
        step();
        @(negedge clk);
        check("fr_c4_waitreq", bus.m_waitrequest, 2'b01);
        check("fr_c4_rdv", bus.m_readdatavalid, 2'b01);
        check("fr_c4_data", bus.m_readdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("fr_c5_waitreq", bus.m_waitrequest, 2'b10);
        check("fr_c5_rdv", bus.m_readdatavalid, 2'b10);
        step();
        idle();

        // Boundary addresses, no aliasing
        drive(0, 1'b0, 1'b1, 13'h1FFF, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        check("bd_addr_top", bus.mem_address, 13'h1FFF);
        step();
        idle();
        drive(1, 1'b0, 1'b1, 13'h0000, 4'hF, 32'h12345678);
        @(negedge clk);
        check("bd_addr_zero", bus.mem_address, 13'h0000);
        step();
        idle();
        drive(0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        step();
        idle();
        drive(1, 1'b1, 1'b0, 13'h0000, 4'hF, 32'h0);
        @(negedge clk);
        check("bd_rdv_top", bus.m_readdatavalid, 2'b01);
        check("bd_data_top", bus.m_readdata, 32'hCAFEF00D);
        step();
        idle();
        @(negedge clk);
        check("bd_rdv_zero", bus.m_readdatavalid, 2'b10);
        check("bd_data_zero", bus.m_readdata, 32'h12345678);

        // Read accepted, then reset in the return cycle
        step();
        drive(0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        @(negedge clk);
        check("rs_accept", bus.m_waitrequest, 2'b00);
        step();
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("rs_rdv_gated", bus.m_readdatavalid, 2'b00);

        // Read presented while reset is high is never accepted
        step();
        drive(0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        @(negedge clk);
        check("rs_waitreq", bus.m_waitrequest, 2'b01);
        check("rs_cs", bus.mem_chipselect, 1'b0);
        step();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("rs_no_rdv", bus.m_readdatavalid, 2'b00);
        step();
        drive(0, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 13'h0000, 4'hF, 32'h0);
        @(negedge clk);
        check("rs_ptr_zero", bus.m_waitrequest, 2'b10);
        step();
        idle();
        @(negedge clk);
        check("rs_post_rdv", bus.m_readdatavalid, 2'b01);
        check("rs_post_data", bus.m_readdata, 32'hCAFEF00D);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
